// File: rtl/gauss_sched_pkg.sv
// Shared types and helpers for the Gauss frame scheduler: FSM states,
// pixel type and the 3x3 window border test.
package gauss_sched_pkg;

  localparam int RGB_W = 24;
  localparam int TAPS  = 9;

  typedef logic [RGB_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_SEND,
    S_DRAIN,
    S_FIN
  } state_e;

  // Tap coordinate is pos + d - 1 with d in 0..2; inside the frame when 0 <= t < lim.
  function automatic logic tap_in_bounds(input int pos, input int d, input int lim);
    int t;
    t = pos + d - 1;
    return (t >= 0) && (t < lim);
  endfunction

endpackage

// File: rtl/gauss_win_addr_gen.sv
// Raster/window walker: x/y pixel counters, dx/dy tap counters, running row
// base of the current tap row, border test, read address and last-tap flag.
module gauss_win_addr_gen
  import gauss_sched_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = 17
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic              o_in_bounds,
  output logic [ADDR_W-1:0] o_tap_addr,
  output logic              o_last_tap
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);
  localparam logic [X_W-1:0]    X_LAST   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [1:0]        dx_q, dx_d;
  logic [1:0]        dy_q, dy_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // row_base tracks (y + dy - 1) * WIDTH modulo 2^ADDR_W; it is only used
  // as an address when the tap row is inside the frame, so the -WIDTH start is harmless.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    row_base_d = row_base_q;
    if (i_clear) begin
      x_d        = '0;
      y_d        = '0;
      dx_d       = '0;
      dy_d       = '0;
      row_base_d = '0 - ROW_STEP;
    end else if (i_advance) begin
      if (dx_q != 2'd2) begin
        dx_d = dx_q + 2'd1;
      end else begin
        dx_d = '0;
        if (dy_q != 2'd2) begin
          dy_d       = dy_q + 2'd1;
          row_base_d = row_base_q + ROW_STEP;
        end else begin
          dy_d = '0;
          if (x_q != X_LAST) begin
            x_d        = x_q + 1'b1;
            row_base_d = row_base_q - (ROW_STEP << 1);
          end else begin
            x_d        = '0;
            y_d        = y_q + 1'b1;
            row_base_d = row_base_q - ROW_STEP;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      x_q        <= '0;
      y_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      row_base_q <= row_base_d;
    end
  end

  assign o_in_bounds = tap_in_bounds(int'(y_q), int'(dy_q), HEIGHT) &&
                       tap_in_bounds(int'(x_q), int'(dx_q), WIDTH);
  assign o_tap_addr  = row_base_q + ADDR_W'(x_q) + ADDR_W'(dx_q) - ADDR_W'(1);
  assign o_last_tap  = (y_q == Y_LAST) && (x_q == X_LAST) && (dy_q == 2'd2) && (dx_q == 2'd2);

endmodule

// File: rtl/gauss_frame_scheduler.sv
// Frame sequencer for the GaussFilter: streams zero-padded 3x3 windows from
// source SRAM into the filter and writes the filter results to the destination region.
module gauss_frame_scheduler
  import gauss_sched_pkg::*;
#(
  parameter int WIDTH    = 256,
  parameter int HEIGHT   = 256,
  parameter int ADDR_W   = 17,
  parameter int DST_BASE = WIDTH * HEIGHT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_done,
  output logic              o_active,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [RGB_W-1:0]  i_rd_data,
  output logic              o_rgb_vld,
  output logic [RGB_W-1:0]  o_rgb_data,
  input  logic              i_rgb_busy,
  input  logic              i_res_vld,
  input  logic [RGB_W-1:0]  i_res_data,
  output logic              o_res_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [RGB_W-1:0]  o_wr_data
);

  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(WIDTH * HEIGHT);
  localparam logic [ADDR_W-1:0] DST_ADDR  = ADDR_W'(DST_BASE);

  state_e            state_q, state_d;
  pixel_t            send_q, send_d;
  logic              vld_q, vld_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] res_cnt_q, res_cnt_d;

  logic              start_ok;
  logic              advance;
  logic              wr_en;
  logic              tap_ok;
  logic              last_tap;
  logic [ADDR_W-1:0] tap_addr;

  assign start_ok = (state_q == S_IDLE) && i_start;
  assign advance  = (state_q == S_SEND) && !i_rgb_busy;
  assign wr_en    = i_res_vld && active_q;

  gauss_win_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (start_ok),
    .i_advance   (advance),
    .o_in_bounds (tap_ok),
    .o_tap_addr  (tap_addr),
    .o_last_tap  (last_tap)
  );

  assign res_cnt_d = start_ok ? '0 : (wr_en ? res_cnt_q + ADDR_W'(1) : res_cnt_q);

  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    send_d   = send_q;
    vld_d    = vld_q;
    active_d = active_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          active_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tap_ok) begin
          state_d = S_WAIT_RD;
        end else begin
          send_d  = '0;
          vld_d   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_WAIT_RD: begin
        send_d  = i_rd_data;
        vld_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!i_rgb_busy) begin
          vld_d   = 1'b0;
          state_d = last_tap ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Looking at the next count lets o_done land one cycle after the final write.
        if (res_cnt_d == FRAME_PIX) begin
          active_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      send_q    <= '0;
      vld_q     <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      send_q    <= send_d;
      vld_q     <= vld_d;
      active_q  <= active_d;
      done_q    <= done_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  // The read strobe is decoded from ISSUE so the data arrives in WAIT_RD.
  assign o_rd_en    = (state_q == S_ISSUE) && tap_ok;
  assign o_rd_addr  = o_rd_en ? tap_addr : '0;
  assign o_rgb_vld  = vld_q;
  assign o_rgb_data = send_q;
  assign o_res_busy = ~active_q;
  assign o_wr_en    = wr_en;
  assign o_wr_addr  = wr_en ? DST_ADDR + res_cnt_q : '0;
  assign o_wr_data  = wr_en ? i_res_data : '0;
  assign o_done     = done_q;
  assign o_active   = active_q;

endmodule

// File: tb/tb_gauss_frame_scheduler.sv
// Scoreboard bench for gauss_frame_scheduler on a 4x3 frame with a summing filter model.
module tb_gauss_frame_scheduler;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 5;
  localparam int NPIX = W * H;
  localparam int DST  = NPIX;

  typedef struct {
    logic [23:0] data;
    int          ready;
  } res_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          o_done, o_active, o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [23:0]   i_rd_data;
  logic          o_rgb_vld;
  logic [23:0]   o_rgb_data;
  logic          i_rgb_busy = 1'b0;
  logic          i_res_vld = 1'b0;
  logic [23:0]   i_res_data = '0;
  logic          o_res_busy, o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [23:0]   o_wr_data;

  gauss_frame_scheduler #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DST_BASE(DST)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_done(o_done), .o_active(o_active),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .i_rgb_busy(i_rgb_busy),
    .i_res_vld(i_res_vld), .i_res_data(i_res_data), .o_res_busy(o_res_busy),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
  );

  always #5 i_clk = ~i_clk;

  logic [23:0]   mem [0:2*NPIX-1];
  logic [23:0]   exp_tap_q[$];
  logic [AW-1:0] exp_wr_addr_q[$];
  logic [23:0]   exp_wr_data_q[$];
  res_t          res_q[$];
  logic [23:0]   log_tap[$];
  logic [AW-1:0] log_wr_addr[$];
  logic [23:0]   log_wr_data[$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_taps = 0, n_wr = 0, n_done = 0;
  int first_vld_cyc = -1, last_tap_cyc = 0, last_wr_cyc = 0, done_cyc = 0, start_cyc = 0;
  int res_delay = 1;
  bit busy_rand = 1'b0, hold_en = 1'b0, hold_done = 1'b0, hold_chk = 1'b0;
  int hold_cnt = 0, hold_taps = 0;
  logic [23:0] acc = '0;
  int acc_n = 0;

  int first9 [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  int last9  [9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc = cyc + 1;

  // Source SRAM read port: data valid the cycle after the strobe.
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

  // Filter input backpressure and filter result presentation.
  always @(negedge i_clk) begin
    if (hold_en && !hold_done && o_rgb_vld && o_rgb_data == 24'd6) begin
      hold_cnt  = 5;
      hold_done = 1'b1;
      hold_taps = n_taps;
    end
    if (hold_cnt > 0) begin
      i_rgb_busy = 1'b1;
      hold_cnt   = hold_cnt - 1;
      hold_chk   = 1'b1;
    end else begin
      hold_chk   = 1'b0;
      i_rgb_busy = busy_rand && ($urandom_range(0, 3) == 0);
    end
    if (i_rst && res_q.size() > 0 && res_q[0].ready <= cyc) begin
      i_res_vld  = 1'b1;
      i_res_data = res_q[0].data;
    end else begin
      i_res_vld  = 1'b0;
      i_res_data = '0;
    end
  end

  // Monitor: compares every tap and write transfer against the scoreboard.
  always @(negedge i_clk) begin
    #1;
    if (i_rst) begin
      if (o_rgb_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (hold_chk) begin
        check("hold_vld", 32'(o_rgb_vld), 32'd1);
        check("hold_data", 32'(o_rgb_data), 32'h6);
        check("hold_rd_en", 32'(o_rd_en), 32'd0);
        check("hold_no_advance", n_taps, hold_taps);
      end
      if (o_rgb_vld && !i_rgb_busy) begin
        if (exp_tap_q.size() == 0) check("tap_unexpected", 32'(o_rgb_data), 32'hFFFF_FFFF);
        else check("tap_data", 32'(o_rgb_data), 32'(exp_tap_q.pop_front()));
        log_tap.push_back(o_rgb_data);
        n_taps++;
        last_tap_cyc = cyc;
        acc = acc + o_rgb_data;
        acc_n++;
        if (acc_n == 9) begin
          res_q.push_back('{acc, cyc + res_delay});
          acc   = '0;
          acc_n = 0;
        end
      end
      if (o_wr_en) begin
        if (res_q.size() > 0) res_q.delete(0);
        if (exp_wr_addr_q.size() == 0) check("wr_unexpected", 32'(o_wr_addr), 32'hFFFF_FFFF);
        else begin
          check("wr_addr", 32'(o_wr_addr), 32'(exp_wr_addr_q.pop_front()));
          check("wr_data", 32'(o_wr_data), 32'(exp_wr_data_q.pop_front()));
        end
        log_wr_addr.push_back(o_wr_addr);
        log_wr_data.push_back(o_wr_data);
        n_wr++;
        last_wr_cyc = cyc;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Reference model: zero-padded 3x3 windows in raster order, results are window sums.
  task automatic prepare_frame(input bit rand_src, input int delay, input bit hold, input bit brand);
    logic [23:0] v, sum;
    int r, c;
    for (int i = 0; i < 2 * NPIX; i++) mem[i] = '0;
    for (int i = 0; i < NPIX; i++) mem[i] = rand_src ? 24'($urandom) : 24'(i + 1);
    exp_tap_q.delete(); exp_wr_addr_q.delete(); exp_wr_data_q.delete(); res_q.delete();
    log_tap.delete(); log_wr_addr.delete(); log_wr_data.delete();
    acc = '0; acc_n = 0; n_taps = 0; n_wr = 0; n_done = 0;
    first_vld_cyc = -1; last_tap_cyc = 0; last_wr_cyc = 0; done_cyc = 0;
    res_delay = delay; hold_en = hold; hold_done = 1'b0; busy_rand = brand;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        sum = '0;
        for (int dy = 0; dy < 3; dy++) begin
          for (int dx = 0; dx < 3; dx++) begin
            r = y + dy - 1;
            c = x + dx - 1;
            v = (r >= 0 && r < H && c >= 0 && c < W) ? mem[r * W + c] : 24'd0;
            exp_tap_q.push_back(v);
            sum = sum + v;
          end
        end
        exp_wr_addr_q.push_back(AW'(DST + y * W + x));
        exp_wr_data_q.push_back(sum);
      end
    end
  endtask

  task automatic start_frame();
    @(negedge i_clk);
    i_start   = 1'b1;
    start_cyc = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_taps(input int n);
    for (int i = 0; i < 4000 && n_taps < n; i++) @(posedge i_clk);
    if (n_taps < n) check("tap_wait_timeout", n_taps, n);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && n_done == 0; i++) @(negedge i_clk);
    if (n_done == 0) check("done_timeout", 32'd0, 32'd1);
    repeat (6) @(negedge i_clk);
  endtask

  task automatic frame_checks(input string tag);
    check({tag, "_tap_count"}, n_taps, NPIX * 9);
    check({tag, "_wr_count"}, n_wr, NPIX);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_taps_left"}, exp_tap_q.size(), 0);
    check({tag, "_wr_left"}, exp_wr_addr_q.size(), 0);
    check({tag, "_done_after_wr"}, done_cyc - last_wr_cyc, 1);
    check({tag, "_active_end"}, 32'(o_active), 32'd0);
    check({tag, "_res_busy_end"}, 32'(o_res_busy), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_active"}, 32'(o_active), 32'd0);
    check({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
    check({tag, "_rgb_vld"}, 32'(o_rgb_vld), 32'd0);
    check({tag, "_rgb_data"}, 32'(o_rgb_data), 32'd0);
    check({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
    check({tag, "_res_busy"}, 32'(o_res_busy), 32'd1);
  endtask

  task automatic known_frame_checks(input string tag);
    if (log_tap.size() < NPIX * 9) check({tag, "_tap_log_size"}, log_tap.size(), NPIX * 9);
    else begin
      for (int i = 0; i < 9; i++) check({tag, "_first_window"}, 32'(log_tap[i]), first9[i]);
      for (int i = 0; i < 9; i++) check({tag, "_last_window"}, 32'(log_tap[NPIX * 9 - 9 + i]), last9[i]);
    end
    if (log_wr_addr.size() < NPIX) check({tag, "_wr_log_size"}, log_wr_addr.size(), NPIX);
    else begin
      check({tag, "_first_wr_addr"}, 32'(log_wr_addr[0]), 32'd12);
      check({tag, "_first_wr_data"}, 32'(log_wr_data[0]), 32'd14);
      check({tag, "_last_wr_addr"}, 32'(log_wr_addr[NPIX - 1]), 32'd23);
      check({tag, "_last_wr_data"}, 32'(log_wr_data[NPIX - 1]), 32'd38);
    end
  endtask

  initial begin
    prepare_frame(1'b0, 1, 1'b0, 1'b0);
    repeat (3) @(posedge i_clk);
    #2;
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    // Known ramp frame with random backpressure and a 5-cycle stall on the 0x000006 tap.
    prepare_frame(1'b0, 1, 1'b1, 1'b1);
    start_frame();
    wait_done();
    frame_checks("ramp");
    known_frame_checks("ramp");
    check("ramp_start_latency", first_vld_cyc - start_cyc, 2);
    check("ramp_hold_seen", 32'(hold_done), 32'd1);

    // Random pixels, slow filter: results trail the last tap, scheduler drains.
    prepare_frame(1'b1, 20, 1'b0, 1'b0);
    start_frame();
    wait_done();
    frame_checks("drain");
    check("drain_gap_ge20", 32'(last_wr_cyc - last_tap_cyc >= 20), 32'd1);

    // Random pixels with a second start pulse mid-frame.
    prepare_frame(1'b1, 1, 1'b0, 1'b1);
    start_frame();
    wait_taps(50);
    start_frame();
    wait_done();
    frame_checks("restart");

    // Abort after the 40th tap with a one-cycle reset, then rerun the ramp frame.
    prepare_frame(1'b0, 1, 1'b0, 1'b1);
    start_frame();
    wait_taps(40);
    #2;
    i_rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_no_done", n_done, 0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    prepare_frame(1'b0, 1, 1'b0, 1'b1);
    repeat (3) @(negedge i_clk);
    check("abort_idle_active", 32'(o_active), 32'd0);
    start_frame();
    wait_done();
    frame_checks("rerun");
    known_frame_checks("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
